// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IFU, the LSU, the arbiter and the memory wrapper.
// master is the arbiter view (it drives the memory port); slave is the surrounding environment.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [63:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    logic        busy;

    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: LSU-priority grant with IFU anti-starvation,
// one transaction in flight (IDLE -> ISSUE -> WAIT).
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_ifu;
    logic             ifu_win;
    logic             lsu_win;

    logic [63:0]      addr_p0;
    logic             wen_p0;
    logic [63:0]      wdata_p0;
    logic [7:0]       wmask_p0;
    logic             owner_lsu_p0;

    logic             ifu_vld_p1;
    logic             lsu_vld_p1;
    logic [63:0]      ifu_rdata_p1;
    logic [63:0]      lsu_rdata_p1;

    assign force_ifu = (STARVE_LIMIT != 0) && (starve_cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        ifu_win   = 1'b0;
        lsu_win   = 1'b0;
        case (state)
            S_IDLE: begin
                // Reset low suppresses grants so nothing is accepted while the arbiter is being cleared.
                if (rst) begin
                    if (bus.lsu_req_valid && !(bus.ifu_req_valid && force_ifu))
                        lsu_win = 1'b1;
                    else if (bus.ifu_req_valid)
                        ifu_win = 1'b1;
                end
                if (ifu_win || lsu_win)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: if (bus.mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            starve_cnt <= '0;
        else if (ifu_win)
            starve_cnt <= '0;
        else if (lsu_win && bus.ifu_req_valid && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Stage p0: request fields latched at grant, held for the whole transaction
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_p0      <= '0;
            wen_p0       <= 1'b0;
            wdata_p0     <= '0;
            wmask_p0     <= '0;
            owner_lsu_p0 <= 1'b0;
        end else if (ifu_win || lsu_win) begin
            addr_p0      <= lsu_win ? bus.lsu_addr : bus.ifu_addr;
            wen_p0       <= lsu_win & bus.lsu_wen;
            wdata_p0     <= lsu_win ? bus.lsu_wdata : '0;
            wmask_p0     <= (lsu_win && bus.lsu_wen) ? bus.lsu_wmask : '0;
            owner_lsu_p0 <= lsu_win;
        end
    end

    // Stage p1: response routed to its owner; rdata holds between responses
    always_ff @(posedge clk) begin
        if (!rst) begin
            ifu_vld_p1   <= 1'b0;
            lsu_vld_p1   <= 1'b0;
            ifu_rdata_p1 <= '0;
            lsu_rdata_p1 <= '0;
        end else begin
            ifu_vld_p1 <= 1'b0;
            lsu_vld_p1 <= 1'b0;
            if (state == S_WAIT && bus.mem_rsp_valid) begin
                if (owner_lsu_p0) begin
                    lsu_vld_p1   <= 1'b1;
                    lsu_rdata_p1 <= wen_p0 ? 64'd0 : bus.mem_rdata;
                end else begin
                    ifu_vld_p1   <= 1'b1;
                    ifu_rdata_p1 <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.ifu_req_ready = ifu_win;
    assign bus.lsu_req_ready = lsu_win;
    assign bus.ifu_rsp_valid = ifu_vld_p1;
    assign bus.ifu_rdata     = ifu_rdata_p1;
    assign bus.lsu_rsp_valid = lsu_vld_p1;
    assign bus.lsu_rdata     = lsu_rdata_p1;
    assign bus.mem_req_valid = (state == S_ISSUE);
    assign bus.mem_addr      = addr_p0;
    assign bus.mem_wen       = wen_p0;
    assign bus.mem_wdata     = wdata_p0;
    assign bus.mem_wmask     = wmask_p0;
    assign bus.busy          = (state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Accepts one transaction at a time, issues it on the memory port with a valid/ready request channel, waits for the response, and returns it to the owning requester.
- Sits between the fetch/MEM stages and the memory wrapper, so that instruction fetch and data access become sequenced multi-cycle transactions.
- The LSU has priority; a starvation counter guarantees the IFU progresses.

Parameters:
- STARVE_LIMIT, 4: consecutive contested arbitrations the LSU may win before the IFU is forced to win. 0 disables forcing, giving pure LSU priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  64  IFU fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, IFU response valid
- ifu_rdata  out  64  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  64  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  64  write data
- lsu_wmask  in  8  byte write mask
- lsu_rsp_valid  out  1  one-cycle pulse, LSU response/ack valid
- lsu_rdata  out  64  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  64  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  64  latched write data
- mem_wmask  out  8  latched mask (0 for reads)
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  64  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst==0 at posedge clk):
  - FSM goes to IDLE and the starve counter clears.
  - All outputs become 0, including the rdata registers and mem_* request fields.
  - An in-flight transaction is abandoned; no rsp_valid pulse is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational ready):
  - Only LSU valid: lsu_req_ready=1.
  - Only IFU valid: ifu_req_ready=1.
  - Both valid: the LSU wins, unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case the IFU wins.
  - At most one ready is high. Both readys are 0 outside IDLE.
- Accept, IDLE with a winner:
  - Latch addr, wen, wdata, wmask (IFU: wen=0, wdata=0, wmask=0) and owner id.
  - Go to ISSUE.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when both are valid and the LSU wins.
  - Clears whenever the IFU wins.
  - Unchanged otherwise.
- ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - When mem_req_ready=1, go to WAIT next cycle.
- WAIT:
  - mem_req_valid=0.
  - When mem_rsp_valid=1, register the response to the owner and go to IDLE.
  - On the next cycle the owner's rsp_valid=1 for exactly one cycle.
  - rdata = mem_rdata for reads, 64'd0 for writes.
- rdata outputs hold their last value between responses.
- mem_rsp_valid is ignored in IDLE and ISSUE, including a same-cycle coincidence with mem_req_ready.
- Minimum latency (req accepted in cycle T, mem_req_ready at T+1, mem_rsp_valid at T+2):
  - rsp_valid at T+3.
  - The next request can be accepted at T+3, same cycle as the response pulse.
- The requester does not need to hold its request after the ready cycle; the arbiter uses only latched fields.
- Throughput: one transaction in flight; no pipelining.

Test Plan:
- Single IFU read: ifu_addr=0x8000_0000, mem ready immediately, rsp next cycle with rdata=0x0000_0013_0000_0297 -> ifu_rsp_valid pulse at T+3 with that data; mem_wen=0, mem_wmask=0.
- LSU write: addr=0x8000_1004, wdata=0xDEAD_BEEF_0000_0000, wmask=0xF0, mem_req_ready delayed 3 cycles -> mem fields stable across the stall; lsu_rsp_valid pulse with lsu_rdata=0.
- Contention, STARVE_LIMIT=4, both valid continuously -> grant order L,L,L,L,I,L,L,L,L,I; the IFU never waits more than 4 contested grants.
- STARVE_LIMIT=0, both valid for 10 transactions -> all grants to the LSU; IFU granted only once lsu_req_valid drops.
- Spurious mem_rsp_valid in IDLE and in ISSUE -> no rsp_valid pulse; FSM state unchanged by it.
- rst=0 asserted in WAIT -> next cycle busy=0, all outputs 0; a later mem_rsp_valid produces no pulse; a fresh IFU request completes normally.
